// File: rtl/sha256_pkg.sv
// Shared defaults and address-check helper for the SHA message memory responder.
// Address checks are pure combinational helpers; no state lives here.
package sha256_pkg;

  localparam int SHA_MEM_LATENCY_DEFAULT = 2;
  localparam int SHA_MEM_DEPTH_DEFAULT   = 1024;

  typedef struct packed {
    logic in_range;
    logic misalign;
  } addr_chk_t;

  // The window is aligned to its own size, so in-range means the bits above
  // the word index match the base address.
  function automatic addr_chk_t chk_addr(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    logic [31:0] hi_mask;
    addr_chk_t   res;
    hi_mask      = ~((32'd1 << (aw + 32'd2)) - 32'd1);
    res.in_range = ((addr ^ base) & hi_mask) == 32'd0;
    res.misalign = addr[1:0] != 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/vld_delay_pipe.sv
// LATENCY-deep valid/data shift register; a stage only loads data when its input is valid,
// so the last stage holds the most recent response. No backpressure; async active-low clear.
module vld_delay_pipe #(
  parameter int LATENCY = 2,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [LATENCY-1:0]         vld_q, vld_d;
  logic [LATENCY-1:0][W-1:0]  dat_q, dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_vld;
    if (in_vld) dat_d[0] = in_dat;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/sha_mem_responder.sv
// Word memory answering read requests exactly LATENCY cycles later, in order, at full rate.
// No backpressure: every request strobe is accepted; host writes never stall reads.
module sha_mem_responder
  import sha256_pkg::*;
#(
  parameter int          DEPTH_WORDS = SHA_MEM_DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = SHA_MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_addr_vld,
  input  logic [31:0] mem_addr,
  output logic        mem_data_vld,
  output logic [31:0] mem_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        err_clr,
  output logic        oob_err,
  output logic        misalign_err,
  output logic [31:0] rd_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  addr_chk_t     rd_chk, wr_chk;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          wr_fire;
  logic [31:0]   rd_dat;
  logic          oob_q, oob_d, mis_q, mis_d;
  logic [31:0]   rd_count_q, rd_count_d;

  always_comb begin
    rd_chk  = chk_addr(mem_addr, BASE_ADDR, AW);
    wr_chk  = chk_addr(wr_addr, BASE_ADDR, AW);
    rd_idx  = mem_addr[AW+1:2];
    wr_idx  = wr_addr[AW+1:2];
    wr_fire = wr_en && wr_chk.in_range;

    // Same-word write in the request cycle wins over the stored word.
    rd_dat = 32'h0;
    if (rd_chk.in_range) rd_dat = (wr_fire && wr_idx == rd_idx) ? wr_data : mem_q[rd_idx];

    oob_d = (oob_q && !err_clr)
          || (mem_addr_vld && !rd_chk.in_range)
          || (wr_en && !wr_chk.in_range);
    mis_d = (mis_q && !err_clr)
          || (mem_addr_vld && rd_chk.misalign)
          || (wr_en && wr_chk.misalign);

    rd_count_d = rd_count_q;
    if (mem_addr_vld && rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
  end

  // Contents are deliberately not reset; software reloads them.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oob_q      <= 1'b0;
      mis_q      <= 1'b0;
      rd_count_q <= 32'h0;
    end else begin
      oob_q      <= oob_d;
      mis_q      <= mis_d;
      rd_count_q <= rd_count_d;
    end
  end

  vld_delay_pipe #(
    .LATENCY (LATENCY),
    .W       (32)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .in_vld  (mem_addr_vld),
    .in_dat  (rd_dat),
    .out_vld (mem_data_vld),
    .out_dat (mem_data)
  );

  assign oob_err      = oob_q;
  assign misalign_err = mis_q;
  assign rd_count     = rd_count_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses with their due cycle; a monitor pops them.
module tb_sha_mem_responder;

  localparam int LAT = 2;

  logic        clk, rst;
  logic        mem_addr_vld, wr_en, err_clr;
  logic [31:0] mem_addr, wr_addr, wr_data;
  logic        mem_data_vld, oob_err, misalign_err;
  logic [31:0] mem_data, rd_count;

  typedef struct packed {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   failures;

  sha_mem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr_vld (mem_addr_vld),
    .mem_addr     (mem_addr),
    .mem_data_vld (mem_data_vld),
    .mem_data     (mem_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .err_clr      (err_clr),
    .oob_err      (oob_err),
    .misalign_err (misalign_err),
    .rd_count     (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the head of the queue and arrive on its due cycle.
  always @(negedge clk) begin
    if (mem_data_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp cyc=%0d got=%h (no response expected)", cyc, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_data !== mon_e.dat || cyc != mon_e.due) begin
          failures++;
          $display("FAIL rsp got=%h@%0d exp=%h@%0d", mem_data, cyc, mon_e.dat, mon_e.due);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      checks++;
      failures++;
      $display("FAIL missing_rsp cyc=%0d exp=%h due=%0d", cyc, exp_q[0].dat, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic rv, input logic [31:0] ra, input logic [31:0] rexp,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic clr, input logic push);
    exp_t e;
    @(posedge clk);
    #1;
    mem_addr_vld = rv;
    mem_addr     = ra;
    wr_en        = we;
    wr_addr      = wa;
    wr_data      = wd;
    err_clr      = clr;
    if (rv && push) begin
      e.dat = rexp;
      e.due = cyc + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [31:0] ra, input logic [31:0] rexp);
    drive(1'b1, ra, rexp, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] wa, input logic [31:0] wd);
    drive(1'b0, 32'h0, 32'h0, 1'b1, wa, wd, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst = 1'b0;
    mem_addr_vld = 1'b0; mem_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", {31'h0, mem_data_vld}, 32'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_oob", {31'h0, oob_err}, 32'h0);
    chk("rst_mis", {31'h0, misalign_err}, 32'h0);
    chk("rst_cnt", rd_count, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Basic read
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    idle(4);
    @(negedge clk);
    chk("hold_data", mem_data, 32'hDEAD_BEEF);

    // Full-rate reads of words 0..15
    for (int k = 0; k < 16; k++) wr(32'(k * 4), 32'(k));
    for (int k = 0; k < 16; k++) rd(32'(k * 4), 32'(k));
    idle(4);
    @(negedge clk);
    chk("cnt_after_burst", rd_count, 32'd17);

    // Out-of-range read, then clear
    rd(32'h1000, 32'h0);
    idle(3);
    @(negedge clk);
    chk("oob_set", {31'h0, oob_err}, 32'h1);
    chk("mis_clean", {31'h0, misalign_err}, 32'h0);
    chk("cnt_oob", rd_count, 32'd18);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    chk("oob_clr", {31'h0, oob_err}, 32'h0);

    // Misaligned read and same-cycle collision
    rd(32'h13, 32'h4);
    idle(3);
    @(negedge clk);
    chk("mis_set", {31'h0, misalign_err}, 32'h1);
    chk("oob_still_clr", {31'h0, oob_err}, 32'h0);
    drive(1'b1, 32'h20, 32'hA5A5_A5A5, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b1);
    rd(32'h20, 32'hA5A5_A5A5);
    // In-flight read unaffected by a later write to the same word
    rd(32'h14, 32'h5);
    wr(32'h14, 32'h55);
    rd(32'h14, 32'h55);
    // Clear and out-of-range write together: set wins, array untouched
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h1004, 32'hBAD0_BAD0, 1'b1, 1'b1);
    rd(32'h04, 32'h1);
    idle(4);
    @(negedge clk);
    chk("set_wins_oob", {31'h0, oob_err}, 32'h1);
    chk("mis_cleared", {31'h0, misalign_err}, 32'h0);
    chk("hold_last", mem_data, 32'h1);
    chk("cnt_before_rst", rd_count, 32'd24);

    // Reset mid-operation: only the response due before reset may appear
    drive(1'b1, 32'h00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h04, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h08, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_addr_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(5);
    @(negedge clk);
    chk("cnt_after_rst", rd_count, 32'h0);
    chk("data_after_rst", mem_data, 32'h0);
    chk("oob_after_rst", {31'h0, oob_err}, 32'h0);
    chk("q_empty_rst", 32'(exp_q.size()), 32'h0);

    // Array survives reset
    rd(32'h20, 32'hA5A5_A5A5);
    idle(4);
    @(negedge clk);
    chk("q_empty_end", 32'(exp_q.size()), 32'h0);
    chk("cnt_end", rd_count, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, 16 to 65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to word 0; must be aligned to DEPTH_WORDS*4.
REQ-003 Parameter LATENCY, default 2, cycles from read request to response; legal range 1 to 8.
REQ-004 Port clk input 1: single clock; all logic on its rising edge.
REQ-005 Port rst input 1: reset, asynchronous assert and active-low; synchronous deassert is the integrator's job.
REQ-006 Port mem_addr_vld input 1: read request strobe; one request per high cycle.
REQ-007 Port mem_addr input 32: read byte address.
REQ-008 Port mem_data_vld output 1: read response strobe.
REQ-009 Port mem_data output 32: read response word.
REQ-010 Port wr_en input 1: host write strobe.
REQ-011 Port wr_addr input 32: host write byte address, same map as mem_addr.
REQ-012 Port wr_data input 32: host write word.
REQ-013 Port err_clr input 1: clears the sticky error flags.
REQ-014 Port oob_err output 1: sticky flag, an address outside the window was seen.
REQ-015 Port misalign_err output 1: sticky flag, an address with [1:0] != 0 was seen.
REQ-016 Port rd_count output 32: number of read requests accepted; saturates at all-ones.

Function
REQ-017 Protocol has no backpressure: every cycle with mem_addr_vld=1 is accepted, back-to-back at full rate.
REQ-018 Response timing: mem_data_vld rises exactly LATENCY cycles after the request cycle; responses stay in order.
REQ-019 Address decode: in range when BASE_ADDR <= addr < BASE_ADDR+DEPTH_WORDS*4; word index = (addr-BASE_ADDR)>>2.
REQ-020 Misaligned address: the low two bits are ignored for the lookup and misalign_err is set.
REQ-021 Out-of-range read: a response is still returned on time, with mem_data = 32'h0, and oob_err is set.
REQ-022 Out-of-range write: the array is unchanged and oob_err is set.
REQ-023 Write-first: a read and a write to the same word in the same cycle return wr_data.
REQ-024 Write stalls: writes never stall reads and never alter responses already in flight.
REQ-025 mem_data when idle: holds its last value while mem_data_vld=0.
REQ-026 Flag priority: if err_clr and a new error occur in the same cycle, the flag is set (set wins).
REQ-027 rd_count: increments once per accepted request, including error requests; holds at 32'hFFFF_FFFF.

Reset
REQ-028 Reset values: mem_data_vld=0, mem_data=0, oob_err=0, misalign_err=0, rd_count=0, all pipeline valids=0.
REQ-029 Reset mid-operation: in-flight requests are discarded; no mem_data_vld for them after reset releases.
REQ-030 Array contents are not reset; software reloads them through the write port.

Structure
REQ-031 Package sha256_pkg holds SHA_MEM_LATENCY_DEFAULT and SHA_MEM_DEPTH_DEFAULT.
REQ-032 One sub-module, vld_delay_pipe: a LATENCY-deep valid/data shift register with async active-low clear.
REQ-033 Array: behavioural register or inferred RAM; read-path registers total exactly LATENCY stages.

Verification
REQ-034 Basic read: write 0xDEADBEEF to 0x10; read 0x10 -> mem_data_vld exactly 2 cycles later with 0xDEADBEEF.
REQ-035 Full-rate reads: write word k = k for k = 0..15; read 0x00..0x3C back-to-back for 16 cycles -> 16 consecutive responses 0..15 in order; rd_count=16.
REQ-036 Out-of-range read: read 0x1000 (DEPTH_WORDS=1024) -> response 0x0 on time; oob_err=1; err_clr then clears it.
REQ-037 Misaligned read and collision:
  - read 0x13 -> returns word 4 and misalign_err=1;
  - same-cycle write 0xA5A5A5A5 plus read of 0x20 -> returns 0xA5A5A5A5.
REQ-038 Reset mid-operation: issue 3 reads, then assert rst in the cycle after the last read -> no mem_data_vld after release; rd_count=0.
